range_sum_ctrl: RTL and testbench
=================================

# range_sum_ctrl

Sequencing controller for the `count_combs` prefix-count datapath. It accepts a stream of inclusive ranges [lo, hi] and, for each range, runs `count_combs` twice: once for hi and once for lo−1. For each query it drives a local reset, holds the operand, and waits for the result. It accumulates count(hi) − count(lo−1) into a batch total and presents that total after the range flagged last. It sits between the input range parser and the result/readout logic.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH ``, operand/result width (matches `count_combs`).
- `TIMEOUT`, default 256, maximum cycles to wait for `cc_valid` per query.
- `MIN_VALID`, default 11, smallest operand passed to the datapath; smaller operands yield 0 without a query.
- `clock` in 1, system clock.
- `reset` in 1, reset, synchronous, active-high.
- `range_valid` in 1, range offered.
- `range_ready` out 1, controller can accept a range.
- `range_lo` in DATA_WIDTH, inclusive lower bound.
- `range_hi` in DATA_WIDTH, inclusive upper bound.
- `range_last` in 1, final range of the batch.
- `cc_reset` out 1, synchronous reset to the `count_combs` instance.
- `cc_n` out DATA_WIDTH, operand to `count_combs.n_in`.
- `cc_valid` in 1, `count_combs.count_out_valid`.
- `cc_count` in DATA_WIDTH, `count_combs.count_out`.
- `total` out DATA_WIDTH, batch accumulator.
- `total_valid` out 1, batch complete.
- `busy` out 1, a range is in flight.
- `err` out 1, sticky error flag.

## Operation
- FSM states: IDLE, CLR_HI, WAIT_HI, CLR_LO, WAIT_LO, ACCUM, DONE.
- `range_ready` = 1 only in IDLE and DONE. A handshake is `range_valid & range_ready`.
  - On the handshake, lo, hi and last are registered.
  - In DONE, the handshake also clears `total` to 0 and deasserts `total_valid` on the next cycle.
- Invalid range: if hi < lo, set `err`, treat the range as contributing 0, and go directly to ACCUM.
- Hi query:
  - If hi < MIN_VALID, cnt_hi = 0 and the hi query is skipped.
  - Otherwise enter CLR_HI: `cc_reset`=1 and `cc_n`=hi for exactly 1 cycle.
  - Then WAIT_HI: `cc_reset`=0 and `cc_n` held at hi. On the first cycle with `cc_valid`=1, capture cnt_hi = `cc_count`.
- Lo query:
  - If lo−1 < MIN_VALID (including lo = 0, with no underflow computed), cnt_lo = 0 and the query is skipped.
  - Otherwise run CLR_LO/WAIT_LO identically with operand lo−1.
- Watchdog: a counter is cleared on entry to each WAIT state.
  - If it reaches TIMEOUT without `cc_valid`, set `err`, force that count to 0, and continue.
- ACCUM (1 cycle): `total` <= `total` + (cnt_hi − cnt_lo), modulo 2^DATA_WIDTH.
  - If last, go to DONE. Otherwise go to IDLE.
- DONE: `total_valid`=1 and `total` held until the next handshake.
- `cc_valid` is ignored in CLR states and outside WAIT states.
- `busy` = 1 in every state except IDLE and DONE.
- `err` clears only on `reset`.

## Timing
- Reset values:
  - `range_ready`=0 during reset, then 1 in IDLE the cycle after reset.
  - `cc_reset`=1 while `reset` is asserted; `reset` ORs into `cc_reset`.
  - `cc_n`=0, `total`=0, `total_valid`=0, `busy`=0, `err`=0.
- Reset mid-operation: return to IDLE next cycle. Registered range, counts and watchdog are discarded.
- Per-range latency from handshake to the `total` update, where Lh/Ll are the cycles in WAIT (≥1 each):
  - Both queries: 1 (CLR_HI) + Lh + 1 (CLR_LO) + Ll + 1 (ACCUM).
  - Skipped query: its CLR and WAIT cycles are removed.
  - Invalid range: 1 cycle (ACCUM only).
- `total` is visible the cycle after ACCUM. `total_valid` rises the same cycle when last.
- Back-to-back ranges: the next handshake may occur the cycle after ACCUM (in IDLE). Throughput is one range per latency, with no overlap.
- `cc_n` changes only on entry to a CLR state. It is stable for the whole query.

## Test plan
Bench stub for `count_combs`: returns `cc_count` = n, with `cc_valid` asserted 6 cycles after `cc_reset` falls and held until the next `cc_reset`.
- Single range lo=50, hi=100, last=1 → `cc_n` sequence 100 then 49; `total`=51; `total_valid`=1; `err`=0. Latency 1+6+1+6+1 = 15 cycles.
- lo=5, hi=20, last=1 → lo query skipped (4 < 11), only 20 issued; `total`=20. Then lo=3, hi=9 → no queries; contributes 0.
- Three ranges (100..200, 300..300, 1000..1010), last on the third → `total` = 101+1+11 = 113. `range_ready` low whenever `busy`=1. `total_valid` only after the third range.
- hi=40, lo=50 → `err`=1, no `cc_reset` pulse, `total` unchanged. The next valid range is processed normally.
- Stub never asserts `cc_valid` on the hi query (TIMEOUT=16) → `err`=1 after 16 WAIT_HI cycles; cnt_hi=0. The lo query still issues. `total` wraps to 2^DATA_WIDTH − (lo−1).
- `reset` asserted during WAIT_LO → next cycle: IDLE, `busy`=0, `total`=0, `err`=0, `cc_reset`=1 during reset. A new range afterwards yields the correct result.

Source files
------------

// File: rtl/range_sum_ctrl.sv
// range_sum_ctrl: sequences count_combs queries for each inclusive range
// [lo, hi]. It computes count(hi) - count(lo-1) and accumulates the result
// into a batch total, which is presented after the range flagged last.

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module range_sum_ctrl #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TIMEOUT    = 256,
  parameter int MIN_VALID  = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  range_valid,
  output logic                  range_ready,
  input  logic [DATA_WIDTH-1:0] range_lo,
  input  logic [DATA_WIDTH-1:0] range_hi,
  input  logic                  range_last,
  output logic                  cc_reset,
  output logic [DATA_WIDTH-1:0] cc_n,
  input  logic                  cc_valid,
  input  logic [DATA_WIDTH-1:0] cc_count,
  output logic [DATA_WIDTH-1:0] total,
  output logic                  total_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int                    WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] MIN_V   = DATA_WIDTH'(MIN_VALID);
  localparam logic [WD_W-1:0]       WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_HI,
    S_WAIT_HI,
    S_CLR_LO,
    S_WAIT_LO,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t                r_state;
  // The hi operand is not kept separately: r_cc_n holds it for the whole hi query.
  logic [DATA_WIDTH-1:0] r_lo;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_cnt_hi;
  logic [DATA_WIDTH-1:0] r_cnt_lo;
  logic [DATA_WIDTH-1:0] r_total;
  logic [DATA_WIDTH-1:0] r_cc_n;
  logic                  r_cc_reset;
  logic                  r_range_ready;
  logic                  r_total_valid;
  logic                  r_busy;
  logic                  r_err;
  logic [WD_W-1:0]       r_wd;

  logic w_handshake;
  logic w_range_ok;
  logic w_hi_query;
  logic w_lo_query;
  logic w_wd_expired;
  logic w_query_end;

  assign w_handshake  = range_valid & r_range_ready;
  assign w_range_ok   = (range_hi >= range_lo);
  assign w_hi_query   = (range_hi >= MIN_V);
  // lo-1 >= MIN_VALID rewritten as lo > MIN_VALID so lo = 0 never underflows.
  assign w_lo_query   = (r_lo > MIN_V);
  assign w_wd_expired = (r_wd == WD_LAST);
  // A WAIT state ends on a result or when the watchdog runs out.
  assign w_query_end  = cc_valid | w_wd_expired;

  // Main sequencer: state, operand/pulse generation, capture and accumulation.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_lo          <= '0;
      r_last        <= 1'b0;
      r_cnt_hi      <= '0;
      r_cnt_lo      <= '0;
      r_total       <= '0;
      r_cc_n        <= '0;
      r_cc_reset    <= 1'b0;
      r_range_ready <= 1'b1;
      r_total_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_wd          <= '0;
    end else begin
      r_cc_reset <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_handshake) begin
            r_lo          <= range_lo;
            r_last        <= range_last;
            r_cnt_hi      <= '0;
            r_cnt_lo      <= '0;
            r_range_ready <= 1'b0;
            r_busy        <= 1'b1;
            if (r_state == S_DONE) begin
              r_total       <= '0;
              r_total_valid <= 1'b0;
            end
            if (!w_range_ok) begin
              r_err   <= 1'b1;
              r_state <= S_ACCUM;
            end else if (w_hi_query) begin
              r_cc_n     <= range_hi;
              r_cc_reset <= 1'b1;
              r_state    <= S_CLR_HI;
            end else begin
              // hi below MIN_VALID with lo <= hi means lo-1 is below it too.
              r_state <= S_ACCUM;
            end
          end
        end
        S_CLR_HI: begin
          r_wd    <= '0;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (w_query_end) begin
            r_cnt_hi <= cc_valid ? cc_count : '0;
            if (!cc_valid) r_err <= 1'b1;
            if (w_lo_query) begin
              r_cc_n     <= r_lo - DATA_WIDTH'(1);
              r_cc_reset <= 1'b1;
              r_state    <= S_CLR_LO;
            end else begin
              r_state <= S_ACCUM;
            end
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_CLR_LO: begin
          r_wd    <= '0;
          r_state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (w_query_end) begin
            r_cnt_lo <= cc_valid ? cc_count : '0;
            if (!cc_valid) r_err <= 1'b1;
            r_state <= S_ACCUM;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_ACCUM: begin
          r_total       <= r_total + (r_cnt_hi - r_cnt_lo);
          r_range_ready <= 1'b1;
          r_busy        <= 1'b0;
          if (r_last) begin
            r_total_valid <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_range_ready <= 1'b1;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  // The system reset also holds the datapath in reset and blocks new ranges.
  assign cc_reset    = r_cc_reset | reset;
  assign range_ready = r_range_ready & ~reset;
  assign cc_n        = r_cc_n;
  assign total       = r_total;
  assign total_valid = r_total_valid;
  assign busy        = r_busy;
  assign err         = r_err;

endmodule

// File: tb/tb_range_sum_ctrl.sv
// Testbench for range_sum_ctrl with a count_combs stub that returns n.
`timescale 1ns/1ps
module tb_range_sum_ctrl;

  localparam int DW   = 16;
  localparam int TO   = 16;
  localparam int MINV = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          range_valid = 1'b0;
  logic          range_last = 1'b0;
  logic [DW-1:0] range_lo = '0;
  logic [DW-1:0] range_hi = '0;
  logic          range_ready;
  logic          cc_reset;
  logic [DW-1:0] cc_n;
  logic          cc_valid;
  logic [DW-1:0] cc_count;
  logic [DW-1:0] total;
  logic          total_valid;
  logic          busy;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  range_sum_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO), .MIN_VALID(MINV)) dut (
    .clock(clock), .reset(reset),
    .range_valid(range_valid), .range_ready(range_ready),
    .range_lo(range_lo), .range_hi(range_hi), .range_last(range_last),
    .cc_reset(cc_reset), .cc_n(cc_n), .cc_valid(cc_valid), .cc_count(cc_count),
    .total(total), .total_valid(total_valid), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // count_combs stub: result = n, valid 6 cycles after cc_reset falls,
  // suppressed entirely for the operand hang_n.
  int            stub_cnt = 0;
  logic [DW-1:0] hang_n = '1;
  always @(posedge clock) begin
    if (cc_reset) stub_cnt <= 0;
    else if (stub_cnt < 6) stub_cnt <= stub_cnt + 1;
  end
  assign cc_valid = !cc_reset && (stub_cnt >= 5) && (cc_n != hang_n);
  assign cc_count = cc_n;

  typedef struct {
    logic [DW-1:0] total;
    int            lat;
    bit            last;
    bit            err;
  } exp_t;

  exp_t          exp_r_q[$];
  logic [DW-1:0] exp_n_q[$];
  logic [DW-1:0] acc = '0;
  bit            exp_err = 1'b0;
  bit            batch_done = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  // Reference: count(n) = n when n >= MIN_VALID, else 0; a hung query counts 0.
  function automatic void model(input logic [DW-1:0] lo, input logic [DW-1:0] hi, input bit last);
    exp_t          e;
    logic [DW-1:0] ch;
    logic [DW-1:0] cl;
    int            lat;
    if (batch_done) acc = '0;
    ch  = '0;
    cl  = '0;
    lat = 1;
    if (hi < lo) begin
      exp_err = 1'b1;
    end else begin
      if (hi >= MINV) begin
        exp_n_q.push_back(hi);
        lat += 1;
        if (hi == hang_n) begin
          lat += TO;
          exp_err = 1'b1;
        end else begin
          ch = hi;
          lat += 6;
        end
      end
      if (lo >= MINV + 1) begin
        cl = lo - 16'd1;
        exp_n_q.push_back(cl);
        lat += 7;
      end
    end
    acc = acc + ch - cl;
    e.total = acc;
    e.lat   = lat;
    e.last  = last;
    e.err   = exp_err;
    exp_r_q.push_back(e);
    batch_done = last;
  endfunction

  // Monitor: checks each query operand and each completed range.
  bit   prev_busy = 1'b0;
  bit   saw_reset = 1'b0;
  int   busy_cycles = 0;
  exp_t got;
  always @(negedge clock) begin
    if (reset) begin
      saw_reset   = 1'b1;
      busy_cycles = 0;
    end else begin
      if (cc_reset) begin
        if (exp_n_q.size() == 0) chk("cc_n_unexpected_query", {16'd0, cc_n}, 32'hFFFF_FFFF);
        else chk("cc_n", {16'd0, cc_n}, {16'd0, exp_n_q.pop_front()});
      end
      if (busy) begin
        busy_cycles++;
        chk("ready_while_busy", {31'd0, range_ready}, 32'd0);
      end else if (prev_busy && !saw_reset) begin
        if (exp_r_q.size() == 0) begin
          chk("range_unexpected", 32'd1, 32'd0);
        end else begin
          got = exp_r_q.pop_front();
          $display("range done: total=%0d valid=%0d err=%0d latency=%0d", total, total_valid, err, busy_cycles);
          chk("total", {16'd0, total}, {16'd0, got.total});
          chk("total_valid", {31'd0, total_valid}, {31'd0, got.last});
          chk("err", {31'd0, err}, {31'd0, got.err});
          chk("latency", busy_cycles, got.lat);
        end
        busy_cycles = 0;
      end
      saw_reset = 1'b0;
    end
    prev_busy = busy;
  end

  task automatic send(input logic [DW-1:0] lo, input logic [DW-1:0] hi, input bit last);
    int t = 0;
    while (!range_ready && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    if (t >= 300) chk("ready_timeout", 32'd0, 32'd1);
    range_lo    = lo;
    range_hi    = hi;
    range_last  = last;
    range_valid = 1'b1;
    model(lo, hi, last);
    @(posedge clock); #1;
    range_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_r_q.size() != 0 || busy) && t < 1000) begin
      @(posedge clock); #1;
      t++;
    end
    if (t >= 1000) chk("drain_timeout", 32'd0, 32'd1);
    chk("queries_missing", exp_n_q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cc_reset", {31'd0, cc_reset}, 32'd1);
    chk("rst_range_ready", {31'd0, range_ready}, 32'd0);
    chk("rst_outputs", {busy, err, total_valid, 13'd0, total}, 32'd0);
    chk("rst_cc_n", {16'd0, cc_n}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("ready_after_reset", {31'd0, range_ready}, 32'd1);
    chk("cc_reset_after_reset", {31'd0, cc_reset}, 32'd0);

    // Directed cases
    send(16'd50, 16'd100, 1'b1);   drain();
    send(16'd5, 16'd20, 1'b1);     drain();
    send(16'd3, 16'd9, 1'b1);      drain();
    send(16'd100, 16'd200, 1'b0);
    send(16'd300, 16'd300, 1'b0);
    send(16'd1000, 16'd1010, 1'b1); drain();
    send(16'd11, 16'd11, 1'b0);
    send(16'd12, 16'd40, 1'b1);    drain();
    chk("err_clean", {31'd0, err}, 32'd0);

    // Hi query never answers: watchdog, count forced to 0, total wraps
    hang_n = 16'd500;
    send(16'd30, 16'd500, 1'b1);   drain();
    hang_n = '1;

    // Reset during WAIT_LO
    send(16'd200, 16'd300, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_cc_reset", {31'd0, cc_reset}, 32'd1);
    chk("mid_rst_ready", {31'd0, range_ready}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_r_q.delete();
    exp_n_q.delete();
    acc = '0;
    exp_err = 1'b0;
    batch_done = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_total", {16'd0, total}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_ready_idle", {31'd0, range_ready}, 32'd1);
    send(16'd12, 16'd40, 1'b1);    drain();

    // Invalid range, then a normal one
    send(16'd50, 16'd40, 1'b0);
    send(16'd60, 16'd70, 1'b1);    drain();

    // Randomized ranges
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 600));
      b = 16'($urandom_range(0, 600));
      if ($urandom_range(0, 7) == 0) begin
        if (a == b) b = a + 16'd1;
        send((a > b) ? b : a, (a > b) ? a : b, 1'b0);
        send((a > b) ? a : b, (a > b) ? b : a, $urandom_range(0, 3) == 0);
      end else begin
        send((a > b) ? b : a, (a > b) ? a : b, (i == 39) || ($urandom_range(0, 3) == 0));
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
